// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment driver with per-digit value buffer and prescaled scan.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seg_scan_display #(
   parameter int N_DIGITS = 6,
   parameter int SCAN_DIV = 50000,
   parameter int HEX_MODE = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic [2:0]          wr_idx,
   input  logic [3:0]          wr_data,
   input  logic [N_DIGITS-1:0] dp_mask,
   output logic [N_DIGITS-1:0] sel,
   output logic [7:0]          dig,
   output logic                frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0]       pre_cnt;
   logic                slot_tick;
   logic [2:0]          scan_idx;
   logic [2:0]          nxt_idx;
   logic [3:0]          digit_buf [N_DIGITS];
   logic [3:0]          nxt_code;
   logic                nxt_dp;
   logic                nxt_blank;
   logic [N_DIGITS-1:0] lz_blank;
   logic                zero_run;

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      if (HEX_MODE == 0 && code > 4'd9) seg = 7'h7F;
      return seg;
   endfunction

   assign slot_tick = (pre_cnt == CW'(SCAN_DIV - 1));
   assign nxt_idx   = (scan_idx == 3'(N_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;

   // A digit blanks when it and every digit to its left hold zero; digit 0 always shows.
   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
`ifdef SEG_LZB_EN
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_run    = zero_run && (digit_buf[k] == 4'd0);
         lz_blank[k] = zero_run && (k != 0);
      end
`endif
   end

   always_comb begin
      nxt_code  = '0;
      nxt_dp    = 1'b0;
      nxt_blank = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (nxt_idx == 3'(k)) begin
            nxt_code  = digit_buf[k];
            nxt_dp    = dp_mask[k];
            nxt_blank = lz_blank[k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (slot_tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + CW'(1);
      end
   end

   // Select and segments load together on the slot edge so no digit shows another's pattern.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_idx   <= 3'(N_DIGITS - 1);
         sel        <= '1;
         dig        <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= slot_tick && (nxt_idx == 3'd0);
         if (slot_tick) begin
            scan_idx <= nxt_idx;
            sel      <= ~(N_DIGITS'(1) << nxt_idx);
            dig      <= {~nxt_dp, nxt_blank ? 7'h7F : decode(nxt_code)};
         end
      end
   end

   // Write port: fire-and-forget strobe, no ready; one value accepted per cycle when wr_en is
   // high, and indices beyond the last digit simply match no buffer entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_DIGITS; k++) digit_buf[k] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            if (wr_idx == 3'(k)) digit_buf[k] <= wr_data;
         end
      end
   end

endmodule
